// File: rtl/addsub_accumulator_if.sv
// Operand/result bundle for addsub_accumulator.
// Both ports follow valid/ready rules: a transfer happens on a rising clk
// edge where valid and ready are both high. A source holds valid and its
// payload until that edge, and ready never depends combinationally on the
// valid of the same port.
// master: operand source and result consumer. slave: the accumulator.
interface addsub_accumulator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             in_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_acc;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_sub, in_clear, out_ready,
    input  in_ready, out_valid, out_acc, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_clear, out_ready,
    output in_ready, out_valid, out_acc, out_cout, out_ovf
  );
endinterface

// File: rtl/addsub_accumulator.sv
// Split-half add/subtract accumulator.
// An accepted operand is added to, or subtracted from, the running
// accumulator. The low half is computed in one cycle and the high half in
// the next, with the carry between the halves held in a register, so only a
// WIDTH/2 adder sits on the critical path.
// FSM: IDLE -> LO -> HI -> DONE -> IDLE. The current state is exposed on
// dbg_state_o.
// Optional macro ADDSUB_ACC_SATURATE_EN: on signed overflow, write the
// signed limit into the accumulator instead of the wrapped sum.
// WIDTH must be even and at least 4.
module addsub_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  addsub_accumulator_if.slave  bus,
  output logic [1:0]           dbg_state_o
);
  localparam int HALF = WIDTH / 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // accumulator operand (0 when cleared)
  logic [WIDTH-1:0] b_q, b_d;      // operand, already inverted for subtract
  logic             cin_q, cin_d;  // +1 that completes the two's complement
  logic [HALF-1:0]  lo_q, lo_d;    // low half of the sum, kept internal
  logic             cmid_q, cmid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [HALF:0]    sum_lo;
  logic [HALF:0]    sum_hi;
  logic [WIDTH-1:0] result;
  logic             ovf_w;
  logic [WIDTH-1:0] acc_next;

  // Each half-adder is used in only one state. The shared operand
  // registers keep both of them narrow.
  assign sum_lo = {1'b0, a_q[HALF-1:0]} + {1'b0, b_q[HALF-1:0]}
                + {{HALF{1'b0}}, cin_q};
  assign sum_hi = {1'b0, a_q[WIDTH-1:HALF]} + {1'b0, b_q[WIDTH-1:HALF]}
                + {{HALF{1'b0}}, cmid_q};
  assign result = {sum_hi[HALF-1:0], lo_q};

  // Signed overflow: both adder inputs have the same sign and the result's
  // sign differs from it. b is the inverted operand when subtracting, so
  // this one rule covers both add and subtract.
  assign ovf_w = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (result[WIDTH-1] != a_q[WIDTH-1]);

`ifdef ADDSUB_ACC_SATURATE_EN
  // On overflow, clamp toward the sign of a: positive a saturates to the
  // maximum, negative a saturates to the minimum.
  assign acc_next = ovf_w ? (a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}})
                          : result;
`else
  assign acc_next = result;
`endif

  // Next-state and datapath control for the four-state sequence
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    lo_d    = lo_q;
    cmid_d  = cmid_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_clear ? '0 : acc_q;
          b_d     = bus.in_data ^ {WIDTH{bus.in_sub}};
          cin_d   = bus.in_sub;
          state_d = S_LO;
        end
      end
      S_LO: begin
        lo_d    = sum_lo[HALF-1:0];
        cmid_d  = sum_lo[HALF];
        state_d = S_HI;
      end
      S_HI: begin
        acc_d   = acc_next;
        cout_d  = sum_hi[HALF];
        ovf_d   = ovf_w;
        state_d = S_DONE;
      end
      default: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State registers; a synchronous reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      lo_q    <= '0;
      cmid_q  <= 1'b0;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      lo_q    <= lo_d;
      cmid_q  <= cmid_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake flags decode the state directly, so out_ready has no
  // combinational path to in_ready.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_acc   = acc_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_addsub_accumulator.sv
// Testbench for addsub_accumulator.
// Stimulus drives the operand port. A reference model built on plain signed
// and unsigned integer arithmetic queues each expected {acc, cout, ovf}.
// A negedge monitor pops from that queue on every result handshake and also
// checks the accept-to-valid timing.
module tb_addsub_accumulator;
  localparam int W = 32;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_accumulator_if #(.WIDTH(W)) bus();

  addsub_accumulator #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W+1:0] exp_q[$];      // {acc, cout, ovf}
  int           acc_cyc_q[$];  // cycle count at each accepting edge
  logic [W-1:0] model_acc;
  logic         prev_valid = 1'b0;
  logic [W+1:0] mon_exp;
  int           mon_cyc;
  logic [W-1:0] corners[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h0000_FFFF};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: integer arithmetic on the operand values
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic sub);
    longint       sa, sb, ssum;
    logic [63:0]  ua, ub;
    logic [W-1:0] res;
    logic         cout, ovf;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ssum = sub ? sa - sb : sa + sb;
    ovf  = (ssum > SMAX) || (ssum < SMIN);
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    cout = sub ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
    res  = sub ? a - b : a + b;
`ifdef ADDSUB_ACC_SATURATE_EN
    if (ovf) res = (ssum > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {res, cout, ovf};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      // out_valid rises after the third rising edge, counting the
      // accepting edge as the first one (accept, LO, HI).
      if (bus.out_valid && !prev_valid) begin
        if (acc_cyc_q.size() == 0) check("unexpected_valid", bus.out_valid, 1'b0);
        else begin
          mon_cyc = acc_cyc_q.pop_front();
          check("latency", cyc, mon_cyc + 2);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", bus.out_valid, 1'b0);
        else begin
          mon_exp = exp_q.pop_front();
          check("sb_acc",  bus.out_acc,  mon_exp[W+1:2]);
          check("sb_cout", bus.out_cout, mon_exp[1]);
          check("sb_ovf",  bus.out_ovf,  mon_exp[0]);
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [W-1:0] d, input logic sub, input logic clr,
                        output logic [W+1:0] e);
    int t = 0;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sub   = sub;
    bus.in_clear = clr;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_sub   = 1'($urandom_range(0, 1));
    bus.in_clear = 1'($urandom_range(0, 1));
    e = model(clr ? '0 : model_acc, d, sub);
    model_acc = e[W+1:2];
    exp_q.push_back(e);
    acc_cyc_q.push_back(cyc);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.out_valid && t < 10) begin
      @(posedge clk); #1; t++;
    end
    check("out_valid_timeout", bus.out_valid, 1'b1);
  endtask

  task automatic drain(input int delay);
    wait_valid();
    repeat (delay) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_drain",  bus.in_ready,  1'b1);
    check("out_valid_after_drain", bus.out_valid, 1'b0);
  endtask

  task automatic op_expect(input logic [W-1:0] d, input logic sub, input logic clr,
                           input logic [W-1:0] xacc, input logic xcout,
                           input logic xovf, input string name);
    logic [W+1:0] e;
    accept(d, sub, clr, e);
    wait_valid();
    check({name, "_acc"},  bus.out_acc,  xacc);
    check({name, "_cout"}, bus.out_cout, xcout);
    check({name, "_ovf"},  bus.out_ovf,  xovf);
    drain(0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W+1:0] e;
    logic [W-1:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sub    = 1'b0;
    bus.in_clear  = 1'b0;
    bus.out_ready = 1'b0;
    model_acc     = '0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_acc",   bus.out_acc,   32'h0);
    check("rst_cout",  bus.out_cout,  1'b0);
    check("rst_ovf",   bus.out_ovf,   1'b0);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_ready", bus.in_ready,  1'b1);
    check("rst_state", dbg_state,     2'd0);

    // Load, then accumulate
    op_expect(32'd5, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0, "load5");
    op_expect(32'd3, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0, "add3");

    // Subtract with borrow
    op_expect(32'd5, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0, "load5b");
    op_expect(32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub7");

    // Carry crossing the half boundary; out_acc only changes on the HI edge
    op_expect(32'h0000_FFFF, 1'b0, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, "loadffff");
    accept(32'd1, 1'b0, 1'b0, e);
    check("xh_lo_acc",   bus.out_acc, 32'h0000_FFFF);
    check("xh_lo_state", dbg_state,   2'd1);
    @(posedge clk); #1;
    check("xh_hi_acc",   bus.out_acc, 32'h0000_FFFF);
    check("xh_hi_state", dbg_state,   2'd2);
    @(posedge clk); #1;
    check("xh_done_acc", bus.out_acc, 32'h0001_0000);
    check("xh_done_state", dbg_state, 2'd3);
    drain(0);

    // Signed overflow
    op_expect(32'h7FFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, "loadmax");
`ifdef ADDSUB_ACC_SATURATE_EN
    op_expect(32'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, "ovf_sat");
`else
    op_expect(32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_wrap");
`endif

    // Back-pressure in DONE: outputs hold, in_valid pulses are ignored
    accept(32'h0000_1234, 1'b0, 1'b1, e);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_ready", bus.in_ready,  1'b0);
      check("hold_acc",   bus.out_acc,   e[W+1:2]);
      check("hold_cout",  bus.out_cout,  e[1]);
      check("hold_ovf",   bus.out_ovf,   e[0]);
      check("hold_state", dbg_state,     2'd3);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = $urandom;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("hold_acc_end", bus.out_acc, e[W+1:2]);
    drain(0);
    check("hold_state_idle", dbg_state, 2'd0);

    // Reset during HI abandons the operation
    op_expect(32'h10, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, "load10");
    accept(32'd5, 1'b0, 1'b0, e);
    @(posedge clk); #1;
    check("abort_hi_state", dbg_state,   2'd2);
    check("abort_hi_acc",   bus.out_acc, 32'h10);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_acc",   bus.out_acc,   32'h0);
    check("abort_valid", bus.out_valid, 1'b0);
    check("abort_state", dbg_state,     2'd0);
    check("abort_ready", bus.in_ready,  1'b1);
    check("abort_cout",  bus.out_cout,  1'b0);
    check("abort_ovf",   bus.out_ovf,   1'b0);
    reset = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    model_acc = '0;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      accept(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), e);
      drain($urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
